reg_write_arbiter: RTL and testbench

- Shares one parameterized enable-register (data in, clock, enable; data out) between NREQ writers.
- Round-robin arbitration; drives the register's d/enable; confirms each write by reading back the register output.
- Sits between requesting datapath stages and the shared register. The register has no reset, so this block owns all write sequencing.

---
 rtl/reg_arb_pkg.sv | 21 ++
 rtl/reg_write_arbiter_rr_pick.sv | 41 ++++
 rtl/reg_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared types and default sizing for the register write
//               arbiter: FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    localparam int unsigned c_WIDTH_DEFAULT = 32;
    localparam int unsigned c_NREQ_DEFAULT  = 4;
    localparam int unsigned c_IDW_DEFAULT   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches req_i starting at
//               ptr_i+1 (modulo NREQ) and returns the first set index.
// Ports       : req_i    [NREQ-1:0] request vector
//               ptr_i    [IDW-1:0]  index of the last served requester
//               winner_o [IDW-1:0]  selected requester (0 when none)
//               any_o               at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int IDW  = c_IDW_DEFAULT
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_o
);

    // Walk from lowest to highest priority so the highest-priority hit
    // (smallest offset from ptr) is the last one written.
    always_comb begin
        int idx;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_i[idx]) begin
                winner_o = IDW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter sharing one enable-register (no reset)
//               between NREQ writers. Each write is driven for one cycle,
//               then verified by reading back the register output; a
//               mismatch sets a sticky error flag.
// Ports       : clk, rst_n (sync, active-low)
//               req[NREQ], wdata[NREQ*WIDTH]     requester side
//               ack[NREQ]                        one-cycle commit pulse
//               reg_d, reg_en / reg_q            shared register side
//               grant_id, busy, err              status
// Options     : REG_ARB_LOCK_EN adds input lock[NREQ]; a locked winner that
//               keeps requesting is re-granted back-to-back (burst).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int NREQ  = c_NREQ_DEFAULT,
    parameter int IDW   = c_IDW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_en,
    input  logic [WIDTH-1:0]      reg_q,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic                  err
);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  reg_d_q, reg_d_d;
    logic              reg_en_q, reg_en_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [IDW-1:0]    ptr_q, ptr_d;

    logic [IDW-1:0]    w_rr_win;
    logic              w_rr_any;
    logic [IDW-1:0]    w_pick_id;
    logic              w_pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (w_rr_win),
        .any_o    (w_rr_any)
    );

`ifdef REG_ARB_LOCK_EN
    // Set in ACK when the winner holds its lock; only honoured in the very
    // next IDLE cycle.
    logic lock_hold_q, lock_hold_d;

    always_comb begin
        w_pick_id  = w_rr_win;
        w_pick_any = w_rr_any;
        if (lock_hold_q && req[grant_q]) begin
            w_pick_id  = grant_q;
            w_pick_any = 1'b1;
        end
    end
`else
    always_comb begin
        w_pick_id  = w_rr_win;
        w_pick_any = w_rr_any;
    end
`endif

    always_comb begin
        state_d  = state_q;
        ack_d    = '0;
        reg_d_d  = reg_d_q;
        reg_en_d = 1'b0;
        grant_d  = grant_q;
        busy_d   = busy_q;
        err_d    = err_q;
        ptr_d    = ptr_q;
`ifdef REG_ARB_LOCK_EN
        lock_hold_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    grant_d  = w_pick_id;
                    reg_d_d  = wdata[int'(w_pick_id)*WIDTH +: WIDTH];
                    reg_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                // Register captures reg_d at this edge; ack rises with it so
                // it is visible during the read-back cycle.
                ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
                state_d = ACK;
            end
            ACK: begin
                ptr_d   = grant_q;
                if (reg_q != reg_d_q) begin
                    err_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef REG_ARB_LOCK_EN
                lock_hold_d = lock[grant_q];
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            reg_d_q  <= '0;
            reg_en_q <= 1'b0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ptr_q    <= IDW'(NREQ - 1);
`ifdef REG_ARB_LOCK_EN
            lock_hold_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            reg_d_q  <= reg_d_d;
            reg_en_q <= reg_en_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
`ifdef REG_ARB_LOCK_EN
            lock_hold_q <= lock_hold_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign reg_d    = reg_d_q;
    assign reg_en   = reg_en_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter. Models the shared
//               enable-register, queues expected (requester, read-back) pairs
//               and compares them against every ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk    = 1'b0;
    logic                  rst_n  = 1'b0;
    logic [NREQ-1:0]       req    = '0;
    logic [NREQ*WIDTH-1:0] wdata  = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      reg_d;
    logic                  reg_en;
    logic [WIDTH-1:0]      reg_q;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  err;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]       lock   = '0;
`endif

    logic [WIDTH-1:0]      shadow = '0;
    logic                  fault  = 1'b0;

    always #5 clk = ~clk;

    // Shared enable-register model; fault forces a broken read-back path.
    always @(posedge clk) if (reg_en) shadow <= reg_d;
    assign reg_q = fault ? '0 : shadow;

    reg_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
`ifdef REG_ARB_LOCK_EN
        .lock     (lock),
`endif
        .ack      (ack),
        .reg_d    (reg_d),
        .reg_en   (reg_en),
        .reg_q    (reg_q),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t            sb[$];
    int              checks   = 0;
    int              errors   = 0;
    int              cyc      = 0;
    int              last_ack = -1;
    int              n_acks   = 0;
    int              n_en     = 0;
    bit              gap_chk  = 1'b0;
    logic [NREQ-1:0] keep     = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [WIDTH-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] d);
        wdata[i*WIDTH +: WIDTH] = d;
    endtask

    // One cycle: sample at the falling edge, score any ack, and let acked
    // requesters drop req unless asked to keep it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reg_en) n_en++;
        if (ack != '0) begin
            n_acks++;
            if (sb.size() == 0) begin
                check("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_vec", 64'(ack), 64'd1 << e.id);
                check("ack_gid", 64'(grant_id), 64'(e.id));
                check("ack_regq", 64'(reg_q), 64'(e.data));
                if (gap_chk && last_ack >= 0)
                    check("ack_gap", 64'(cyc - last_ack), 64'd3);
            end
            last_ack = cyc;
            req = req & ~(ack & ~keep);
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target;
        int t;
        target = n_acks + n;
        t      = 0;
        while (n_acks < target && t < budget) begin
            tick();
            t++;
        end
        if (n_acks < target) check("ack_timeout", 64'(n_acks), 64'(target));
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, then a single write
        do_reset();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_en", 64'(reg_en), 64'd0);
        check("rst_regd", 64'(reg_d), 64'd0);
        check("rst_gid", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        set_data(0, 32'hDEADBEEF);
        push(0, 32'hDEADBEEF);
        req  = 4'b0001;
        n_en = 0;
        tick();
        check("t1_en", 64'(reg_en), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_regd", 64'(reg_d), 64'hDEADBEEF);
        tick();
        check("t1_en_off", 64'(reg_en), 64'd0);
        check("t1_ack", 64'(ack), 64'd1);
        tick();
        check("t1_ack_off", 64'(ack), 64'd0);
        check("t1_busy_off", 64'(busy), 64'd0);
        check("t1_err", 64'(err), 64'd0);
        check("t1_en_cnt", 64'(n_en), 64'd1);
        check("t1_gid_hold", 64'(grant_id), 64'd0);

        // 2: all four request at once after reset -> 0,1,2,3, 3 cycles apart
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_data(i, WIDTH'(i + 1));
            push(i, WIDTH'(i + 1));
        end
        req      = 4'b1111;
        gap_chk  = 1'b1;
        last_ack = -1;
        wait_acks(4, 40);
        gap_chk  = 1'b0;
        tick();
        check("t2_regq", 64'(reg_q), 64'd4);

        // 3: ptr=3, req 1001 -> 0 wins; 0 keeps requesting -> 3 next
        set_data(0, 32'hA0A0A0A0);
        set_data(3, 32'hB3B3B3B3);
        push(0, 32'hA0A0A0A0);
        push(3, 32'hB3B3B3B3);
        keep = 4'b0001;
        req  = 4'b1001;
        wait_acks(2, 20);
        req  = '0;
        keep = '0;
        tick();
        tick();
        check("t3_idle", 64'(busy), 64'd0);

        // 4: move ptr to 1, then abort a write to 2 with reset
        set_data(1, 32'h0000_0101);
        push(1, 32'h0000_0101);
        req = 4'b0010;
        wait_acks(1, 10);
        tick();
        set_data(2, 32'h0000_0077);
        req = 4'b0100;
        tick();
        check("t4_write", 64'(reg_en), 64'd1);
        rst_n = 1'b0;
        req   = '0;
        tick();
        check("t4_en_off", 64'(reg_en), 64'd0);
        check("t4_busy_off", 64'(busy), 64'd0);
        check("t4_no_ack", 64'(ack), 64'd0);
        rst_n = 1'b1;
        tick();
        check("t4_no_ack2", 64'(ack), 64'd0);
        // ptr back at 3: requester 0 beats 3
        set_data(0, 32'h0000_00A0);
        set_data(3, 32'h0000_00B3);
        push(0, 32'h0000_00A0);
        push(3, 32'h0000_00B3);
        req = 4'b1001;
        wait_acks(2, 20);
        set_data(1, 32'h0000_0011);
        push(1, 32'h0000_0011);
        req = 4'b0010;
        wait_acks(1, 10);
        tick();

        // 5: read-back fault sets sticky err
        do_reset();
        fault = 1'b1;
        set_data(0, 32'h5);
        push(0, 32'h0);
        req = 4'b0001;
        wait_acks(1, 10);
        check("t5_regd", 64'(reg_d), 64'h5);
        check("t5_err_pre", 64'(err), 64'd0);
        tick();
        check("t5_err", 64'(err), 64'd1);
        fault = 1'b0;
        set_data(1, 32'h6);
        push(1, 32'h6);
        req = 4'b0010;
        wait_acks(1, 10);
        tick();
        check("t5_err_sticky", 64'(err), 64'd1);
        do_reset();
        check("t5_err_clr", 64'(err), 64'd0);

`ifdef REG_ARB_LOCK_EN
        // 6: locked requester 0 is re-granted before 1
        set_data(0, 32'h11);
        set_data(1, 32'h22);
        push(0, 32'h11);
        push(0, 32'h11);
        push(1, 32'h22);
        lock = 4'b0001;
        keep = 4'b0001;
        req  = 4'b0011;
        wait_acks(1, 10);
        keep = '0;
        wait_acks(2, 20);
        lock = '0;
        tick();
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_write_arbiter
`default_nettype wire
